// File: rtl/data_mem_arbiter_if.sv
// Request/grant/read-data bundle between the two requesters (CU, PN) and the
// shared data-memory arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              cu_req;
  logic              cu_we;
  logic [ADDR_W-1:0] cu_addr;
  logic [DATA_W-1:0] cu_wdata;
  logic              cu_lock;
  logic              cu_gnt;
  logic              cu_rvalid;
  logic [DATA_W-1:0] cu_rdata;

  logic              pn_req;
  logic              pn_we;
  logic [ADDR_W-1:0] pn_addr;
  logic [DATA_W-1:0] pn_wdata;
  logic              pn_gnt;
  logic              pn_rvalid;
  logic [DATA_W-1:0] pn_rdata;
  logic              pn_starved;

  modport master (
    output cu_req, cu_we, cu_addr, cu_wdata, cu_lock,
    input  cu_gnt, cu_rvalid, cu_rdata,
    output pn_req, pn_we, pn_addr, pn_wdata,
    input  pn_gnt, pn_rvalid, pn_rdata, pn_starved
  );

  modport slave (
    input  cu_req, cu_we, cu_addr, cu_wdata, cu_lock,
    output cu_gnt, cu_rvalid, cu_rdata,
    input  pn_req, pn_we, pn_addr, pn_wdata,
    output pn_gnt, pn_rvalid, pn_rdata, pn_starved
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Single-port operand/result memory shared by the multiply control unit (high
// priority, lockable) and the front-panel scanner (low priority, anti-starvation).
module data_mem_arbiter #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  data_mem_arbiter_if.slave  bus
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  typedef enum logic {FREE, CU_LOCKED} state_t;

  state_t            state;
  logic [3:0]        wcnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              cu_gnt_c;
  logic              pn_gnt_c;
  logic              cu_vld_p1;
  logic              pn_vld_p1;
  logic [DATA_W-1:0] cu_rdata_p1;
  logic [DATA_W-1:0] pn_rdata_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_CNT) ? MAX_CNT : v + 4'd1;
  endfunction

  // Grant decode: a starved PN beats the CU only while the port is unlocked.
  always_comb begin
    cu_gnt_c = 1'b0;
    pn_gnt_c = 1'b0;
    if (!reset) begin
      if (state == CU_LOCKED)
        cu_gnt_c = bus.cu_req;
      else if (bus.pn_req && (wcnt == MAX_CNT))
        pn_gnt_c = 1'b1;
      else if (bus.cu_req)
        cu_gnt_c = 1'b1;
      else if (bus.pn_req)
        pn_gnt_c = 1'b1;
    end
  end

  // Control: lock FSM, PN wait counter, read-valid strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FREE;
      wcnt      <= 4'd0;
      cu_vld_p1 <= 1'b0;
      pn_vld_p1 <= 1'b0;
    end else begin
      case (state)
        FREE:      if (cu_gnt_c && bus.cu_lock) state <= CU_LOCKED;
        CU_LOCKED: if (!bus.cu_lock) state <= FREE;
        default:   state <= FREE;
      endcase
      if (!bus.pn_req || pn_gnt_c)
        wcnt <= 4'd0;
      else if (state == FREE)
        wcnt <= sat_inc(wcnt);
      cu_vld_p1 <= cu_gnt_c && !bus.cu_we;
      pn_vld_p1 <= pn_gnt_c && !bus.pn_we;
    end
  end

  // Storage and read-data registers; grants are mutually exclusive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cu_rdata_p1 <= '0;
      pn_rdata_p1 <= '0;
    end else begin
      if (cu_gnt_c) begin
        if (bus.cu_we) mem[bus.cu_addr] <= bus.cu_wdata;
        else           cu_rdata_p1      <= mem[bus.cu_addr];
      end else if (pn_gnt_c) begin
        if (bus.pn_we) mem[bus.pn_addr] <= bus.pn_wdata;
        else           pn_rdata_p1      <= mem[bus.pn_addr];
      end
    end
  end

  assign bus.cu_gnt     = cu_gnt_c;
  assign bus.pn_gnt     = pn_gnt_c;
  assign bus.cu_rvalid  = cu_vld_p1;
  assign bus.pn_rvalid  = pn_vld_p1;
  assign bus.cu_rdata   = cu_rdata_p1;
  assign bus.pn_rdata   = pn_rdata_p1;
  assign bus.pn_starved = (wcnt == MAX_CNT);

endmodule
